// File: rtl/johnson_decoder.sv
// Johnson code decoder with sequence-lock FSM and registered status pulses.
// Optional saturating error counter is built when JOHNSON_DEC_ERR_CNT_EN is defined.
module johnson_decoder #(
    parameter int unsigned N        = 4,
    parameter int unsigned LOCK_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [N-1:0]            johnson_in,
    output logic [$clog2(2*N)-1:0]  index,
    output logic                    index_valid,
    output logic                    illegal,
    output logic                    seq_err,
    output logic                    locked,
    output logic [7:0]              err_count
);

    localparam int unsigned IW = $clog2(2*N);
    localparam int unsigned PW = IW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(2*N - 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t          state;
    logic [3:0]      run;
    logic            have_ref;
    logic [IW-1:0]   dec_idx;
    logic [IW-1:0]   next_idx;
    logic            legal;
    logic            succ;
    logic [3:0]      run_inc;

    function automatic logic [IW-1:0] decode(input logic [N-1:0] w);
        logic [PW-1:0] pop;
        pop = '0;
        for (int unsigned i = 0; i < N; i++) pop = pop + PW'(w[i]);
        if (w[N-1]) decode = IW'(PW'(2*N) - pop);
        else        decode = IW'(pop);
    endfunction

    // Bit i is set for states 0..N when i < k, and for states N+1..2N-1 when i >= k-N.
    function automatic logic [N-1:0] encode(input logic [IW-1:0] k);
        int unsigned ki;
        ki = 32'(k);
        for (int unsigned i = 0; i < N; i++) begin
            if (ki <= N) encode[i] = (i < ki);
            else         encode[i] = (i >= ki - N);
        end
    endfunction

    always_comb begin
        dec_idx  = decode(johnson_in);
        legal    = (encode(dec_idx) == johnson_in);
        next_idx = (index == LAST_IDX) ? '0 : index + 1'b1;
        succ     = have_ref && (dec_idx == next_idx);
        run_inc  = run + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= HUNT;
            run         <= '0;
            have_ref    <= 1'b0;
            index       <= '0;
            index_valid <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            index_valid <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
            if (in_valid) begin
                if (!legal) begin
                    illegal  <= 1'b1;
                    state    <= HUNT;
                    run      <= '0;
                    have_ref <= 1'b0;
                end else begin
                    index       <= dec_idx;
                    index_valid <= 1'b1;
                    have_ref    <= 1'b1;
                    if (state == LOCKED) begin
                        if (!succ) begin
                            seq_err <= 1'b1;
                            state   <= HUNT;
                            run     <= '0;
                        end
                    end else if (succ) begin
                        run <= run_inc;
                        if (run_inc >= 4'(LOCK_CNT)) state <= LOCKED;
                    end else begin
                        run <= '0;
                    end
                end
            end
        end
    end

    assign locked = (state == LOCKED);

`ifdef JOHNSON_DEC_ERR_CNT_EN
    logic err_event;
    assign err_event = in_valid && (!legal || (state == LOCKED && !succ));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               err_count <= '0;
        else if (err_event && err_count != '1)  err_count <= err_count + 8'd1;
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed and randomized bench for johnson_decoder (N=4, LOCK_CNT=3) against a table-driven model.
module tb_johnson_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] johnson_in = '0;
    logic [2:0] index;
    logic       index_valid, illegal, seq_err, locked;
    logic [7:0] err_count;

    johnson_decoder #(.N(4), .LOCK_CNT(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .johnson_in(johnson_in),
        .index(index), .index_valid(index_valid), .illegal(illegal),
        .seq_err(seq_err), .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    int m_idx, m_last, m_run, m_errs;
    bit m_have, m_locked, m_iv, m_ill, m_seq;
    logic [3:0] codes [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int lookup(input logic [3:0] w);
        lookup = -1;
        for (int i = 0; i < 8; i++) if (codes[i] == w) lookup = i;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_last = 0; m_run = 0; m_errs = 0;
        m_have = 0; m_locked = 0; m_iv = 0; m_ill = 0; m_seq = 0;
    endtask

    task automatic model_step(input bit v, input logic [3:0] w);
        int k;
        bit s;
        m_iv = 0; m_ill = 0; m_seq = 0;
        if (!v) return;
        k = lookup(w);
        if (k < 0) begin
            m_ill = 1; m_have = 0; m_locked = 0; m_run = 0;
            if (m_errs < 255) m_errs++;
            return;
        end
        s = m_have && (k == (m_last + 1) % 8);
        m_iv = 1; m_idx = k;
        if (m_locked) begin
            if (!s) begin
                m_seq = 1; m_locked = 0; m_run = 0;
                if (m_errs < 255) m_errs++;
            end
        end else begin
            m_run = s ? m_run + 1 : 0;
            if (m_run >= 3) m_locked = 1;
        end
        m_last = k; m_have = 1;
    endtask

    task automatic check_all(input string tag);
        int exp_err;
`ifdef JOHNSON_DEC_ERR_CNT_EN
        exp_err = m_errs;
`else
        exp_err = 0;
`endif
        chk({tag, ".index"}, 32'(index), 32'(m_idx));
        chk({tag, ".index_valid"}, 32'(index_valid), 32'(m_iv));
        chk({tag, ".illegal"}, 32'(illegal), 32'(m_ill));
        chk({tag, ".seq_err"}, 32'(seq_err), 32'(m_seq));
        chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
        chk({tag, ".err_count"}, 32'(err_count), 32'(exp_err));
    endtask

    task automatic drive(input string tag, input bit v, input logic [3:0] w);
        @(negedge clk);
        in_valid = v; johnson_in = w;
        @(posedge clk);
        model_step(v, w);
        #1 check_all(tag);
    endtask

    initial begin
        int r, k;
        codes = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        model_reset();
        #12 check_all("reset");
        @(negedge clk) rst = 1'b1;

        // Lock acquisition and explicit locked-rise point
        drive("acq0", 1, 4'b0000);
        drive("acq1", 1, 4'b0001);
        drive("acq2", 1, 4'b0011);
        drive("acq3", 1, 4'b0111);
        drive("walk4", 1, 4'b1111);
        drive("walk5", 1, 4'b1110);
        drive("walk6", 1, 4'b1100);
        drive("wrap7", 1, 4'b1000);
        drive("wrap0", 1, 4'b0000);

        // Successor check across an idle gap
        for (int i = 0; i < 5; i++) drive("gap", 0, 4'b1010);
        drive("gap_succ", 1, 4'b0001);
        drive("pre_seq", 1, 4'b0011);
        drive("seq_err", 1, 4'b1100);
        drive("illegal", 1, 4'b0101);
        drive("after_ill", 1, 4'b1000);

        // Relock, then asynchronous reset between edges
        drive("rl0", 1, 4'b0000);
        drive("rl1", 1, 4'b0001);
        drive("rl2", 1, 4'b0011);
        chk("relocked", 32'(locked), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk) rst = 1'b1;
        drive("pr0", 1, 4'b0111);
        drive("pr1", 1, 4'b1111);
        drive("pr2", 1, 4'b1110);
        drive("pr3", 1, 4'b1100);

        // Random mix biased toward successors so lock is reached repeatedly
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(99);
            k = (m_have ? m_last + 1 : 0) % 8;
            if (r < 55)      drive("rnd_succ", 1, codes[k]);
            else if (r < 75) drive("rnd_legal", 1, codes[$urandom_range(7)]);
            else if (r < 88) drive("rnd_any", 1, 4'($urandom_range(15)));
            else             drive("rnd_idle", 0, 4'($urandom_range(15)));
        end

        // Drive enough illegal samples to exercise saturation
        for (int i = 0; i < 260; i++) drive("sat", 1, 4'b1001);
        drive("sat_legal", 1, 4'b0011);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter N, default 4: width of the Johnson code word; legal range 2..16; the code has 2N legal states.
REQ-002 Parameter LOCK_CNT, default 3: number of consecutive correct successor samples required to reach LOCKED; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  johnson_in is sampled on this cycle when high.
REQ-006 johnson_in  input  N  Johnson code word from the counter under observation.
REQ-007 index  output  $clog2(2N)  binary state index of the last legal sample, 0..2N-1.
REQ-008 index_valid  output  1  one-cycle pulse: index was updated from a legal sample.
REQ-009 illegal  output  1  one-cycle pulse: the last sample was not a legal Johnson code.
REQ-010 seq_err  output  1  one-cycle pulse: in LOCKED, a legal sample was not the expected successor.
REQ-011 locked  output  1  level: FSM is in LOCKED.
REQ-012 err_count  output  8  saturating count of illegal and seq_err events.

Function
REQ-013 Legal codes (state k): k=0..N gives 2^k-1; k=N+1..2N-1 gives (2^N-1) shifted left by k-N, truncated to N bits (N=4: 0000,0001,0011,0111,1111,1110,1100,1000).
REQ-014 Decode: msb 0 -> index = popcount(johnson_in); msb 1 -> index = 2N - popcount(johnson_in).
REQ-015 A sample is legal iff re-encoding its decoded index per REQ-013 reproduces johnson_in exactly.
REQ-016 Latency: all outputs are registered, one cycle after the in_valid sample; no combinational path from inputs to outputs.
REQ-017 in_valid low: no outputs pulse, index/FSM/run counter hold; successor checks compare against the last valid legal sample regardless of idle gaps.
REQ-018 Expected successor = (last index + 1) mod 2N; 2N-1 wraps to 0.
REQ-019 FSM states: HUNT (reset state) and LOCKED.
REQ-020 HUNT: legal successor sample increments run counter; legal non-successor sample (or first sample after reset) sets run to 0; no seq_err in HUNT.
REQ-021 HUNT -> LOCKED when run reaches LOCK_CNT; locked rises with the index_valid of that sample.
REQ-022 LOCKED: legal successor -> stay; legal non-successor -> seq_err pulse, HUNT, run = 0, index updated to new sample.
REQ-023 Illegal sample in any state: illegal pulse, index holds, index_valid low, HUNT, run = 0, next legal sample treated as first sample.
REQ-024 Illegal takes priority: illegal and seq_err never assert together.
REQ-025 err_count increments by 1 per illegal or seq_err pulse, saturates at 255, never wraps.

Reset
REQ-026 rst low asynchronously forces: FSM HUNT, run 0, index 0, index_valid 0, illegal 0, seq_err 0, locked 0, err_count 0, no "last sample" reference.
REQ-027 Reset asserted mid-sequence discards lock and history; after release, lock requires LOCK_CNT fresh successors.

Configuration
REQ-028 Macro JOHNSON_DEC_ERR_CNT_EN defined: err_count implemented per REQ-025.
REQ-029 Macro undefined: counter not built, err_count port present and tied to 0; all other behaviour unchanged.

Verification (N=4, LOCK_CNT=3)
REQ-030 Reset, then 0000,0001,0011,0111 on consecutive valid cycles -> index 0,1,2,3 one cycle later each; locked rises with index 3.
REQ-031 Locked, drive 1000 then 0000 -> index 7 then 0, no seq_err, locked stays high (wrap-around).
REQ-032 Locked at index 2, drive 1100 -> seq_err pulse, index 6, locked falls, err_count +1.
REQ-033 Drive 0101 -> illegal pulse only, index holds, index_valid low, locked low; 255+ errors -> err_count stays 255 (macro on), always 0 (macro off).
REQ-034 Locked, in_valid low 5 cycles, then next successor -> no pulses during gap, lock retained.
REQ-035 rst low mid-lock asynchronously (between edges) -> all outputs 0 immediately; after release two successors insufficient, third locks.
